exception_ctrl: RTL

//  Exception sequencer directly upstream of the system register file. Arbitrates TLB-miss requests

---
 rtl/exc_pkg.sv | 19 +
 rtl/exc_arbiter.sv | 57 +++++
 rtl/exception_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer.
package exc_pkg;

  // Sequencer states; IRET is answered in the same cycle, so no separate return state is kept.
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StFlush    = 2'd1,
    StRedirect = 2'd2,
    StHandler  = 2'd3
  } exc_state_e;

  localparam logic [1:0] EXC_CAUSE_NONE    = 2'd0;
  localparam logic [1:0] EXC_CAUSE_ITLB    = 2'd1;
  localparam logic [1:0] EXC_CAUSE_DTLB    = 2'd2;
  localparam logic [1:0] EXC_CAUSE_ILLEGAL = 2'd3;

  localparam logic [31:0] DEFAULT_HANDLER_VEC = 32'h0000_1000;

endpackage

// File: rtl/exc_arbiter.sv
// Fixed-priority exception source select: DTLB (oldest instruction) first, then illegal
// instruction when ILLEGAL_INSN_EXC_EN is defined, then ITLB.
module exc_arbiter
  import exc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
`ifdef ILLEGAL_INSN_EXC_EN
  input  logic            illegal_i,
  input  logic [XLEN-1:0] illegal_pc_i,
  output logic [1:0]      cause_o,
`endif
  input  logic            itlb_miss_i,
  input  logic [XLEN-1:0] itlb_pc_i,
  input  logic            dtlb_miss_i,
  input  logic [XLEN-1:0] dtlb_pc_i,
  input  logic [XLEN-1:0] dtlb_addr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] addr_o
);

  // Priority select of the winning source's EPC/BADADDR.
  always_comb begin
    valid_o = 1'b0;
    pc_o    = '0;
    addr_o  = '0;
`ifdef ILLEGAL_INSN_EXC_EN
    cause_o = EXC_CAUSE_NONE;
`endif
    if (dtlb_miss_i) begin
      valid_o = 1'b1;
      pc_o    = dtlb_pc_i;
      addr_o  = dtlb_addr_i;
`ifdef ILLEGAL_INSN_EXC_EN
      cause_o = EXC_CAUSE_DTLB;
`endif
    end
`ifdef ILLEGAL_INSN_EXC_EN
    else if (illegal_i) begin
      valid_o = 1'b1;
      pc_o    = illegal_pc_i;
      addr_o  = illegal_pc_i;
      cause_o = EXC_CAUSE_ILLEGAL;
    end
`endif
    else if (itlb_miss_i) begin
      valid_o = 1'b1;
      pc_o    = itlb_pc_i;
      addr_o  = itlb_pc_i;
`ifdef ILLEGAL_INSN_EXC_EN
      cause_o = EXC_CAUSE_ITLB;
`endif
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception sequencer feeding the system register file: captures TLB misses, pulses TLB_MISS,
// flushes the pipeline, redirects to the handler and sequences IRET back to the saved EPC.
// Optional feature macro: ILLEGAL_INSN_EXC_EN (adds an illegal-instruction source and exc_cause).
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] HANDLER_VEC  = XLEN'(DEFAULT_HANDLER_VEC),
  parameter int unsigned     FLUSH_CYCLES = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            itlb_miss,
  input  logic [XLEN-1:0] itlb_pc,
  input  logic            dtlb_miss,
  input  logic [XLEN-1:0] dtlb_pc,
  input  logic [XLEN-1:0] dtlb_addr,
  input  logic            iret_req,
  input  logic [XLEN-1:0] epc_in,
  input  logic            supervisor_mode,
`ifdef ILLEGAL_INSN_EXC_EN
  input  logic            illegal_insn,
  input  logic [XLEN-1:0] illegal_pc,
  output logic [1:0]      exc_cause,
`endif
  output logic            TLB_MISS,
  output logic [XLEN-1:0] TLB_PC_REG,
  output logic [XLEN-1:0] TLB_ADDR_REG,
  output logic            IRET,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            double_fault
);

  localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  exc_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            miss_q, miss_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            dfault_q, dfault_d;
  logic            iret_take;

  logic            arb_valid;
  logic [XLEN-1:0] arb_pc;
  logic [XLEN-1:0] arb_addr;
`ifdef ILLEGAL_INSN_EXC_EN
  logic [1:0]      arb_cause;
  logic [1:0]      cause_q, cause_d;
`endif

  exc_arbiter #(
    .XLEN(XLEN)
  ) u_arbiter (
`ifdef ILLEGAL_INSN_EXC_EN
    .illegal_i   (illegal_insn),
    .illegal_pc_i(illegal_pc),
    .cause_o     (arb_cause),
`endif
    .itlb_miss_i (itlb_miss),
    .itlb_pc_i   (itlb_pc),
    .dtlb_miss_i (dtlb_miss),
    .dtlb_pc_i   (dtlb_pc),
    .dtlb_addr_i (dtlb_addr),
    .valid_o     (arb_valid),
    .pc_o        (arb_pc),
    .addr_o      (arb_addr)
  );

  // Next-state logic: capture in IDLE, count down flush, redirect, wait for IRET in HANDLER.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    miss_d    = 1'b0;
    pc_d      = pc_q;
    addr_d    = addr_q;
    dfault_d  = dfault_q;
    iret_take = 1'b0;
`ifdef ILLEGAL_INSN_EXC_EN
    cause_d   = cause_q;
`endif
    case (state_q)
      StIdle: begin
        // A pending miss belongs to an older instruction than the IRET, so it wins.
        if (arb_valid) begin
          miss_d  = 1'b1;
          pc_d    = arb_pc;
          addr_d  = arb_addr;
          cnt_d   = CntW'(FLUSH_CYCLES - 1);
          state_d = StFlush;
`ifdef ILLEGAL_INSN_EXC_EN
          cause_d = arb_cause;
`endif
        end else if (iret_req && supervisor_mode) begin
          iret_take = 1'b1;
        end
      end
      StFlush: begin
        if (cnt_q == '0) state_d = StRedirect;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StRedirect: state_d = StHandler;
      StHandler: begin
        if (arb_valid) dfault_d = 1'b1;
        if (iret_req) begin
          iret_take = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and capture registers; reset aborts any sequence in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      miss_q   <= 1'b0;
      pc_q     <= '0;
      addr_q   <= '0;
      dfault_q <= 1'b0;
`ifdef ILLEGAL_INSN_EXC_EN
      cause_q  <= EXC_CAUSE_NONE;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      miss_q   <= miss_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      dfault_q <= dfault_d;
`ifdef ILLEGAL_INSN_EXC_EN
      cause_q  <= cause_d;
`endif
    end
  end

  // Output decode; IRET redirect is combinational so fetch resumes in the same cycle.
  always_comb begin
    TLB_MISS       = miss_q;
    TLB_PC_REG     = pc_q;
    TLB_ADDR_REG   = addr_q;
    double_fault   = dfault_q;
    IRET           = iret_take;
    flush          = (state_q == StFlush) || iret_take;
    redirect_valid = (state_q == StRedirect) || iret_take;
    if (iret_take)                  redirect_pc = epc_in;
    else if (state_q == StRedirect) redirect_pc = HANDLER_VEC;
    else                            redirect_pc = '0;
`ifdef ILLEGAL_INSN_EXC_EN
    exc_cause      = cause_q;
`endif
  end

endmodule
